led_pwm_driver: RTL and testbench
=================================

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per PWM tick, legal range 1..65535.
REQ-002 SHALL have parameter RAMP_EN, default 1: 1 = duty slews by at most 1 LSB per period; 0 = duty jumps directly.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  run control; low holds the PWM idle.
REQ-006 SHALL have port duty_in  input  8  target duty, driven by the 8-bit LED PIO output register.
REQ-007 SHALL have port pwm_out  output  1  registered PWM waveform to the LED pin.
REQ-008 SHALL have port period_start  output  1  one-clk pulse at the start of each PWM period.
REQ-009 SHALL have port duty_active  output  8  duty value currently in force.

Function
REQ-010 SHALL run a prescaler counting 0..CLK_DIV-1 while enable=1 and assert an internal tick when it equals CLK_DIV-1, then wrap to 0.
REQ-011 SHALL tick every clk when CLK_DIV=1.
REQ-012 SHALL advance an 8-bit period counter cnt by 1 on each tick, wrapping 255->0; one period = 256 ticks = 256*CLK_DIV clks.
REQ-013 SHALL update duty_active only on the tick where cnt wraps 255->0 (period boundary) while enable=1.
REQ-014 SHALL, at a boundary with RAMP_EN=1: +1 if duty_in>duty_active, -1 if duty_in<duty_active, hold if equal.
REQ-015 SHALL, at a boundary with RAMP_EN=0, load duty_active <= duty_in.
REQ-016 SHALL ignore duty_in changes mid-period; no glitch or truncated pulse on pwm_out.
REQ-017 SHALL register pwm_out <= enable & (cnt < duty_active), one clk behind cnt/duty_active.
REQ-018 SHALL keep pwm_out low for the whole period when duty_active=0, and high for 255 of 256 ticks when duty_active=255.
REQ-019 SHALL assert period_start for exactly one clk in the cycle cnt becomes 0 via wrap.
REQ-020 SHALL, while enable=0: hold prescaler and cnt at 0; drive pwm_out=0 and period_start=0; load duty_active <= duty_in every clk, with no ramp.
REQ-021 SHALL, on enable 0->1, restart from prescaler=0, cnt=0; the first tick occurs CLK_DIV clks later; no period_start pulse for this restart.
REQ-022 SHALL resolve enable falling in the same cycle as a boundary in favour of enable=0 (REQ-020).
REQ-023 SHALL use unsigned arithmetic only, with no overflow past 0 or 255 during ramping.

Reset
REQ-024 SHALL, while reset_n=0, force prescaler=0, cnt=0, duty_active=0, pwm_out=0, period_start=0 asynchronously.
REQ-025 SHALL leave reset synchronously on the first clk edge after reset_n rises, behaving per REQ-020/REQ-021 from there.
REQ-026 SHALL abandon any in-progress period or ramp on reset mid-operation; no state survives.

Structure
REQ-027 SHALL place PWM_WIDTH=8 and CLK_DIV_DEFAULT=16 in shared package led_pwm_pkg.
REQ-028 SHALL implement the prescaler as sub-module pwm_prescaler (inputs clk, reset_n, enable; output tick; parameter CLK_DIV).
REQ-029 SHALL instantiate exactly one pwm_prescaler; all other logic lives in led_pwm_driver.

Verification
REQ-030 SHALL cover: CLK_DIV=1, RAMP_EN=0, enable=1, duty_in=64 -> after first boundary, pwm_out high 64 clks and low 192 clks per 256-clk period, period_start every 256 clks.
REQ-031 SHALL cover: duty_in=0 then 255 with RAMP_EN=0 -> zero high time, then 255/256 high time from the next boundary.
REQ-032 SHALL cover: RAMP_EN=1, duty_active=10, duty_in=13 -> duty_active reads 11, 12, 13 on three successive boundaries, then holds.
REQ-033 SHALL cover: duty_in changed 100->20 at cnt=50 -> current period completes with 100 high ticks; new duty applies only from the next boundary.
REQ-034 SHALL cover: CLK_DIV=4, enable dropped at cnt=128 -> pwm_out=0 next clk; re-enable -> first tick 4 clks later, first period_start after 1024 clks.
REQ-035 SHALL cover: reset_n pulsed low mid-period with pwm_out=1 -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared widths, defaults and the duty ramp helper for the LED PWM driver.
package led_pwm_pkg;

  localparam int unsigned PWM_WIDTH       = 8;
  localparam int unsigned CLK_DIV_DEFAULT = 16;
  localparam int unsigned PRESC_WIDTH     = 16;

  typedef logic [PWM_WIDTH-1:0] duty_t;

  // One-LSB step of cur toward tgt; cannot overflow because it only moves toward tgt.
  function automatic duty_t ramp_step(input duty_t cur, input duty_t tgt);
    duty_t res;
    res = cur;
    if (tgt > cur) begin
      res = cur + PWM_WIDTH'(1);
    end else if (tgt < cur) begin
      res = cur - PWM_WIDTH'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running 0..CLK_DIV-1 divider; tick marks the last count while enabled.
module pwm_prescaler
  import led_pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam logic [PRESC_WIDTH-1:0] LAST = PRESC_WIDTH'(CLK_DIV - 1);

  logic [PRESC_WIDTH-1:0] count_q;
  logic [PRESC_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!enable || (count_q == LAST)) begin
      count_d = '0;
    end else begin
      count_d = count_q + PRESC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/led_pwm_driver.sv
// 8-bit LED PWM with period-boundary duty update and optional 1-LSB-per-period ramp.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
  parameter int unsigned RAMP_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [PWM_WIDTH-1:0] duty_in,
  output logic                 pwm_out,
  output logic                 period_start,
  output logic [PWM_WIDTH-1:0] duty_active
);

  logic  tick;
  logic  boundary;
  duty_t cnt_q, cnt_d;
  duty_t duty_q, duty_d;
  logic  pwm_q, pwm_d;
  logic  ps_q, ps_d;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  // tick already implies enable, so a disable on the boundary cycle wins.
  assign boundary = tick && (cnt_q == '1);

  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    pwm_d  = 1'b0;
    ps_d   = 1'b0;
    if (!enable) begin
      cnt_d  = '0;
      duty_d = duty_in;
    end else begin
      if (tick) begin
        cnt_d = cnt_q + PWM_WIDTH'(1);
      end
      if (boundary) begin
        duty_d = (RAMP_EN != 0) ? ramp_step(duty_q, duty_in) : duty_in;
      end
      pwm_d = (cnt_q < duty_q);
      ps_d  = boundary;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      ps_q   <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_active  = duty_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench: three driver instances (div1/jump, div1/ramp, div4/jump) on one clock.
module tb_led_pwm_driver;

  logic       clk;
  logic       reset_n;
  logic       en_a, en_b, en_c;
  logic [7:0] duty_a, duty_b, duty_c;
  logic       pwm_a, pwm_b, pwm_c;
  logic       ps_a, ps_b, ps_c;
  logic [7:0] act_a, act_b, act_c;

  int passed = 0;
  int total  = 0;
  int w, hi, psn, highs;
  logic [7:0] exp_d;

  led_pwm_driver #(.CLK_DIV(1), .RAMP_EN(0)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .duty_in(duty_a),
    .pwm_out(pwm_a), .period_start(ps_a), .duty_active(act_a));

  led_pwm_driver #(.CLK_DIV(1), .RAMP_EN(1)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .duty_in(duty_b),
    .pwm_out(pwm_b), .period_start(ps_b), .duty_active(act_b));

  led_pwm_driver #(.CLK_DIV(4), .RAMP_EN(0)) u_c (
    .clk(clk), .reset_n(reset_n), .enable(en_c), .duty_in(duty_c),
    .pwm_out(pwm_c), .period_start(ps_c), .duty_active(act_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for period_start on instance A, then counts one full period cnt=0..255.
  task automatic measure_a(input int chg_at, input logic [7:0] chg_val,
                           output int waited, output int high, output int ps);
    waited = 0;
    while (ps_a !== 1'b1 && waited < 2000) begin
      step(1);
      waited++;
    end
    high = 0;
    ps   = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == chg_at) duty_a = chg_val;
      step(1);
      if (pwm_a === 1'b1) high++;
      if (ps_a === 1'b1) ps++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    duty_a = 8'd64; duty_b = 8'd10; duty_c = 8'd200;
    step(2);
    check("rst_pwm_a",  32'(pwm_a), 32'd0);
    check("rst_ps_a",   32'(ps_a),  32'd0);
    check("rst_act_a",  32'(act_a), 32'd0);
    check("rst_act_c",  32'(act_c), 32'd0);

    reset_n = 1'b1;
    step(3);
    check("dis_act_a", 32'(act_a), 32'd64);
    check("dis_act_b", 32'(act_b), 32'd10);
    check("dis_act_c", 32'(act_c), 32'd200);
    check("dis_pwm_a", 32'(pwm_a), 32'd0);
    check("dis_ps_a",  32'(ps_a),  32'd0);

    // div1 jump mode: 64, then 0, then 255, then mid-period change 100->20
    en_a = 1'b1;
    measure_a(-1, 8'd0, w, hi, psn);
    check("a64_first_ps", 32'(w), 32'd256);
    check("a64_high",     32'(hi), 32'd64);
    check("a64_ps_cnt",   32'(psn), 32'd1);
    duty_a = 8'd0;
    measure_a(-1, 8'd0, w, hi, psn);
    check("a64_latched_wait", 32'(w), 32'd0);
    check("a64_latched_high", 32'(hi), 32'd64);
    measure_a(-1, 8'd0, w, hi, psn);
    check("a0_high", 32'(hi), 32'd0);
    check("a0_ps",   32'(psn), 32'd1);
    duty_a = 8'd255;
    measure_a(-1, 8'd0, w, hi, psn);
    check("a0_latched_high", 32'(hi), 32'd0);
    measure_a(-1, 8'd0, w, hi, psn);
    check("a255_high", 32'(hi), 32'd255);
    duty_a = 8'd100;
    measure_a(-1, 8'd0, w, hi, psn);
    check("a255_latched_high", 32'(hi), 32'd255);
    measure_a(50, 8'd20, w, hi, psn);
    check("a100_midchg_high", 32'(hi), 32'd100);
    check("a100_act", 32'(act_a), 32'd20);
    measure_a(-1, 8'd0, w, hi, psn);
    check("a20_high", 32'(hi), 32'd20);

    // div1 ramp mode: 10 -> 13 one LSB per boundary, then hold
    duty_b = 8'd13;
    en_b = 1'b1;
    for (int j = 0; j < 4; j++) begin
      w = 0;
      while (ps_b !== 1'b1 && w < 600) begin
        step(1);
        w++;
      end
      exp_d = (j < 3) ? 8'(11 + j) : 8'd13;
      check("b_ramp_act", 32'(act_b), 32'(exp_d));
      step(1);
    end
    duty_b = 8'd200;
    step(254);
    check("b_midperiod_hold", 32'(act_b), 32'd13);
    en_b = 1'b0;
    step(1);
    check("b_dis_on_boundary_ps",  32'(ps_b),  32'd0);
    check("b_dis_on_boundary_act", 32'(act_b), 32'd200);
    check("b_dis_on_boundary_pwm", 32'(pwm_b), 32'd0);

    // div4: drop enable at cnt=128, then re-enable with duty 1
    en_c = 1'b1;
    step(512);
    check("c_pwm_before_drop", 32'(pwm_c), 32'd1);
    en_c = 1'b0;
    step(1);
    check("c_pwm_after_drop", 32'(pwm_c), 32'd0);
    check("c_ps_after_drop",  32'(ps_c),  32'd0);
    duty_c = 8'd1;
    step(3);
    check("c_dis_act", 32'(act_c), 32'd1);
    en_c = 1'b1;
    w = 0;
    highs = 0;
    while (ps_c !== 1'b1 && w < 1200) begin
      step(1);
      w++;
      if (w <= 8 && pwm_c === 1'b1) highs++;
    end
    check("c_first_ps_latency", 32'(w), 32'd1024);
    check("c_first_tick_highs", 32'(highs), 32'd4);
    check("c_act_at_boundary",  32'(act_c), 32'd1);

    // asynchronous reset while A is driving high
    w = 0;
    while (pwm_a !== 1'b1 && w < 300) begin
      step(1);
      w++;
    end
    check("a_pwm_high_pre_reset", 32'(pwm_a), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pwm_a", 32'(pwm_a), 32'd0);
    check("async_rst_ps_a",  32'(ps_a),  32'd0);
    check("async_rst_act_a", 32'(act_a), 32'd0);
    check("async_rst_act_c", 32'(act_c), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
